// File: rtl/rv32_ctrl_fsm_pkg.sv
// ---------------------------------------------------------------------------
// rv32_ctrl_fsm_pkg
//   Shared constants for the RV32I multi-cycle control sequencer:
//   opcode and funct3 codes, sequencer state encoding, datapath select
//   encodings, trap causes, the one-hot opcode class record and the
//   registered control-output record.
// ---------------------------------------------------------------------------
package rv32_ctrl_fsm_pkg;

  // RV32I base opcodes (IR[6:0])
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  // funct3 codes (IR[14:12]) used by the branch comparator and SYSTEM decode
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_PRIV = 3'b000;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_e;

  // ALU operand A select
  localparam logic [1:0] OP1_RS1  = 2'd0;
  localparam logic [1:0] OP1_PC   = 2'd1;
  localparam logic [1:0] OP1_ZERO = 2'd2;

  // ALU operand B select
  localparam logic [1:0] OP2_RS2  = 2'd0;
  localparam logic [1:0] OP2_IMM  = 2'd1;
  localparam logic [1:0] OP2_FOUR = 2'd2;

  // Register-file write-back source
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Next-PC source
  localparam logic PC_PLUS4 = 1'b0;
  localparam logic PC_ALU   = 1'b1;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE        = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL     = 2'd1;
  localparam logic [1:0] CAUSE_ECALL       = 2'd2;
  localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'd3;

  // One-hot instruction class; all-zero means the opcode is illegal
  typedef struct packed {
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic load;
    logic store;
    logic op_imm;
    logic op;
    logic misc_mem;
    logic system;
  } op_class_t;

  // Registered control outputs. br_exec marks the EXECUTE cycle of a branch,
  // where pc_sel is taken live from the comparator.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       pc_we;
    logic       pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic [1:0] op1_sel;
    logic [1:0] op2_sel;
    logic       alu_en;
    logic       br_exec;
    logic       trap;
    logic [1:0] trap_cause;
  } ctrl_out_t;

endpackage

// File: rtl/rv32_opcode_class.sv
// ---------------------------------------------------------------------------
// rv32_opcode_class
//   Combinational RV32I opcode classifier.
//   Ports:
//     opcode_i   in  [6:0]       IR[6:0]
//     cls_o      out op_class_t  one-hot instruction class
//     illegal_o  out             opcode is not an RV32I base opcode
// ---------------------------------------------------------------------------
module rv32_opcode_class
  import rv32_ctrl_fsm_pkg::*;
(
  input  logic [6:0] opcode_i,
  output op_class_t  cls_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OPCODE_LUI:      cls_o.lui      = 1'b1;
      OPCODE_AUIPC:    cls_o.auipc    = 1'b1;
      OPCODE_JAL:      cls_o.jal      = 1'b1;
      OPCODE_JALR:     cls_o.jalr     = 1'b1;
      OPCODE_BRANCH:   cls_o.branch   = 1'b1;
      OPCODE_LOAD:     cls_o.load     = 1'b1;
      OPCODE_STORE:    cls_o.store    = 1'b1;
      OPCODE_OP_IMM:   cls_o.op_imm   = 1'b1;
      OPCODE_OP:       cls_o.op       = 1'b1;
      OPCODE_MISC_MEM: cls_o.misc_mem = 1'b1;
      OPCODE_SYSTEM:   cls_o.system   = 1'b1;
      default:         cls_o          = '0;
    endcase
  end

  assign illegal_o = (cls_o == '0);

endmodule

// File: rtl/rv32_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// rv32_ctrl_fsm
//   Multi-cycle RV32I control sequencer: FETCH -> DECODE -> EXECUTE ->
//   [MEM] -> [WRITEBACK] -> FETCH, with a sticky TRAP state left only by rst.
//
//   Memory handshake: mem_req is valid, mem_ready is ready. A transfer
//   completes in a cycle where both are 1. Once raised, mem_req and its
//   qualifiers (mem_we, mem_addr_sel) stay stable until that cycle, unless
//   rst or the wait-timeout trap ends the request.
//
//   Control outputs come from registers loaded with the decode of the next
//   state. ir_we, the store-completion pc_we and the branch pc_sel are the
//   only outputs that also look at live inputs (mem_ready / br_taken).
//   Reset zeroes every output register, so the first FETCH cycle after rst
//   is quiet (mem_req=0) and the request rises one cycle later.
//
//   Parameters: MEM_TIMEOUT (max wait cycles, 0 = no timeout),
//               CNT_W (wait-counter width, must hold MEM_TIMEOUT).
//   Ports: clk, rst (sync, active-high); opcode, funct3 (IR fields);
//          br_taken; mem_ready; mem_req, mem_we, mem_addr_sel; ir_we;
//          pc_we, pc_sel; rf_we, wb_sel; op1_sel, op2_sel, alu_en;
//          trap, trap_cause; state_dbg (current state, debug).
//   Optional: define CTRL_PERF_CNT_EN to add cycle_cnt and instret_cnt.
// ---------------------------------------------------------------------------
module rv32_ctrl_fsm
  import rv32_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [1:0]  op1_sel,
  output logic [1:0]  op2_sel,
  output logic        alu_en,
  output logic        trap,
  output logic [1:0]  trap_cause,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt,
`endif
  output state_e      state_dbg
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  ctrl_out_t        out_q, out_d;
  logic [1:0]       cause_d;

  op_class_t cls;
  logic      illegal;

  // Every SYSTEM opcode traps, so funct3 is not needed for sequencing.
  logic unused_f3;
  assign unused_f3 = ^funct3;

  rv32_opcode_class u_class (
    .opcode_i  (opcode),
    .cls_o     (cls),
    .illegal_o (illegal)
  );

  logic req_done, req_stall, timeout;
  assign req_done  = out_q.mem_req & mem_ready;
  assign req_stall = out_q.mem_req & ~mem_ready;
  // A ready in the limit cycle wins because timeout needs the stall.
  assign timeout   = (MEM_TIMEOUT != 0) && req_stall &&
                     (wait_q == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    state_d = state_q;
    cause_d = out_q.trap_cause;
    wait_d  = wait_q;
    out_d   = '0;

    // Next state
    case (state_q)
      ST_FETCH: begin
        if (req_done) begin
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_MEM_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (illegal) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (cls.system) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ECALL;
        end else if (cls.branch || cls.misc_mem) begin
          state_d = ST_FETCH;
        end else if (cls.load || cls.store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        if (req_done) begin
          state_d = cls.load ? ST_WRITEBACK : ST_FETCH;
        end else if (timeout) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_MEM_TIMEOUT;
        end
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_TRAP:      state_d = ST_TRAP;
      default:      state_d = ST_FETCH;
    endcase

    // Wait counter: restart on entry to a requesting state, saturate.
    if ((state_d != state_q) && (state_d == ST_FETCH || state_d == ST_MEM)) begin
      wait_d = '0;
    end else if (req_stall && (wait_q != {CNT_W{1'b1}})) begin
      wait_d = wait_q + CNT_W'(1);
    end

    // Output decode for the state being entered
    case (state_d)
      ST_FETCH: begin
        out_d.mem_req = 1'b1;
      end
      ST_EXECUTE: begin
        out_d.alu_en = 1'b1;
        if (cls.lui) begin
          out_d.op1_sel = OP1_ZERO;
          out_d.op2_sel = OP2_IMM;
        end else if (cls.auipc || cls.jal || cls.branch) begin
          out_d.op1_sel = OP1_PC;
          out_d.op2_sel = OP2_IMM;
        end else if (cls.jalr || cls.load || cls.store || cls.op_imm) begin
          out_d.op1_sel = OP1_RS1;
          out_d.op2_sel = OP2_IMM;
        end else if (cls.op) begin
          out_d.op1_sel = OP1_RS1;
          out_d.op2_sel = OP2_RS2;
        end
        out_d.pc_we   = cls.branch | cls.misc_mem;
        out_d.br_exec = cls.branch;
      end
      ST_MEM: begin
        out_d.mem_req      = 1'b1;
        out_d.mem_addr_sel = 1'b1;
        out_d.mem_we       = cls.store;
      end
      ST_WRITEBACK: begin
        out_d.rf_we = 1'b1;
        out_d.pc_we = 1'b1;
        if (cls.jal || cls.jalr) begin
          out_d.wb_sel = WB_PC4;
          out_d.pc_sel = PC_ALU;
        end else if (cls.load) begin
          out_d.wb_sel = WB_MEM;
          out_d.pc_sel = PC_PLUS4;
        end else begin
          out_d.wb_sel = WB_ALU;
          out_d.pc_sel = PC_PLUS4;
        end
      end
      ST_TRAP: begin
        out_d.trap       = 1'b1;
        out_d.trap_cause = cause_d;
      end
      default: out_d = '0;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_q, instret_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      out_q   <= out_d;
    end
`ifdef CTRL_PERF_CNT_EN
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else if (state_q != ST_TRAP) begin
      cycle_q <= cycle_q + 32'd1;
      if (pc_we) instret_q <= instret_q + 32'd1;
    end
`endif
  end

  assign mem_req      = out_q.mem_req;
  assign mem_we       = out_q.mem_we;
  assign mem_addr_sel = out_q.mem_addr_sel;
  assign ir_we        = (state_q == ST_FETCH) & req_done;
  // Store retires on the mem_ready of its MEM cycle.
  assign pc_we        = out_q.pc_we | ((state_q == ST_MEM) & out_q.mem_we & req_done);
  assign pc_sel       = out_q.pc_sel | (out_q.br_exec & br_taken);
  assign rf_we        = out_q.rf_we;
  assign wb_sel       = out_q.wb_sel;
  assign op1_sel      = out_q.op1_sel;
  assign op2_sel      = out_q.op2_sel;
  assign alu_en       = out_q.alu_en;
  assign trap         = out_q.trap;
  assign trap_cause   = out_q.trap_cause;
  assign state_dbg    = state_q;

`ifdef CTRL_PERF_CNT_EN
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_rv32_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_rv32_ctrl_fsm
//   Bench for rv32_ctrl_fsm (MEM_TIMEOUT=4). Each instruction is expanded
//   phase by phase into per-cycle stimulus and expected output vectors,
//   which are then replayed against the DUT and compared cycle by cycle.
// ---------------------------------------------------------------------------
module tb_rv32_ctrl_fsm;
  import rv32_ctrl_fsm_pkg::*;

  localparam int TMO = 4;

  localparam logic [6:0] O_LUI    = 7'b0110111;
  localparam logic [6:0] O_AUIPC  = 7'b0010111;
  localparam logic [6:0] O_JAL    = 7'b1101111;
  localparam logic [6:0] O_JALR   = 7'b1100111;
  localparam logic [6:0] O_BRANCH = 7'b1100011;
  localparam logic [6:0] O_LOAD   = 7'b0000011;
  localparam logic [6:0] O_STORE  = 7'b0100011;
  localparam logic [6:0] O_OPIMM  = 7'b0010011;
  localparam logic [6:0] O_OP     = 7'b0110011;
  localparam logic [6:0] O_FENCE  = 7'b0001111;
  localparam logic [6:0] O_SYSTEM = 7'b1110011;

  logic [6:0] legal_ops [11] = '{O_LUI, O_AUIPC, O_JAL, O_JALR, O_BRANCH,
                                 O_LOAD, O_STORE, O_OPIMM, O_OP, O_FENCE, O_SYSTEM};

  // Expected/observed vector layout (20 bits)
  typedef struct packed {
    logic [2:0] st;
    logic       req, we, asel, irwe, pcwe, pcsel, rfwe;
    logic [1:0] wbs, o1, o2;
    logic       alu, trp;
    logic [1:0] cause;
  } vec_t;

  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic       br;
    logic [6:0] op;
  } stim_t;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       br_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we;
  logic [1:0] wb_sel, op1_sel, op2_sel, trap_cause;
  logic       alu_en, trap;
  state_e     state_dbg;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  rv32_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct3       (funct3),
    .br_taken     (br_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .op1_sel      (op1_sel),
    .op2_sel      (op2_sel),
    .alu_en       (alu_en),
    .trap         (trap),
    .trap_cause   (trap_cause),
`ifdef CTRL_PERF_CNT_EN
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt),
`endif
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [19:0] exp_q[$];
  stim_t       stim_q[$];
  string       tag_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  logic [6:0]  cur_op  = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    for (int i = 0; i < 11; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic vec_t blank(input state_e st);
    vec_t v;
    v = '0;
    v.st = st;
    return v;
  endfunction

  task automatic push(input vec_t v, input logic rdy, input logic br, input logic r, input string tag);
    stim_t s;
    s.rst = r;
    s.rdy = rdy;
    s.br  = br;
    s.op  = cur_op;
    stim_q.push_back(s);
    exp_q.push_back(20'(v));
    tag_q.push_back(tag);
  endtask

  // First cycle after a reset edge: FETCH with every output low.
  task automatic plan_quiet();
    push(blank(ST_FETCH), rbit(), rbit(), 1'b0, "post_rst");
  endtask

  task automatic do_trap(input logic [1:0] cause, input int hold);
    vec_t v;
    v = blank(ST_TRAP);
    v.trp = 1'b1;
    v.cause = cause;
    for (int i = 0; i < hold; i++) push(v, rbit(), rbit(), 1'b0, "trap_hold");
    push(v, rbit(), rbit(), 1'b1, "trap_rst");
    plan_quiet();
  endtask

  // fw/mw: stall cycles before mem_ready in FETCH/MEM (> TMO means never ready)
  task automatic plan_instr(input logic [6:0] op, input logic br, input int fw,
                            input int mw, input bit rst_in_mem, input int hold);
    vec_t f, e, m, w;
    int   nst;
    f = blank(ST_FETCH);
    f.req = 1'b1;
    nst = (fw > TMO) ? TMO + 1 : fw;
    for (int i = 0; i < nst; i++) push(f, 1'b0, rbit(), 1'b0, "fetch_wait");
    if (fw > TMO) begin
      do_trap(2'd3, hold);
      return;
    end
    f.irwe = 1'b1;
    push(f, 1'b1, rbit(), 1'b0, "fetch_done");
    cur_op = op;
    push(blank(ST_DECODE), rbit(), rbit(), 1'b0, "decode");
    if (!is_legal(op)) begin
      do_trap(2'd1, hold);
      return;
    end
    e = blank(ST_EXECUTE);
    e.alu = 1'b1;
    case (op)
      O_LUI:                           begin e.o1 = 2'd2; e.o2 = 2'd1; end
      O_AUIPC, O_JAL, O_BRANCH:        begin e.o1 = 2'd1; e.o2 = 2'd1; end
      O_JALR, O_LOAD, O_STORE, O_OPIMM: begin e.o1 = 2'd0; e.o2 = 2'd1; end
      default:                         begin e.o1 = 2'd0; e.o2 = 2'd0; end
    endcase
    if (op == O_BRANCH) begin
      e.pcwe = 1'b1;
      e.pcsel = br;
      push(e, rbit(), br, 1'b0, "exec_branch");
      return;
    end
    if (op == O_FENCE) begin
      e.pcwe = 1'b1;
      push(e, rbit(), rbit(), 1'b0, "exec_fence");
      return;
    end
    push(e, rbit(), rbit(), 1'b0, "exec");
    if (op == O_SYSTEM) begin
      do_trap(2'd2, hold);
      return;
    end
    if (op == O_LOAD || op == O_STORE) begin
      m = blank(ST_MEM);
      m.req = 1'b1;
      m.asel = 1'b1;
      m.we = (op == O_STORE);
      if (rst_in_mem) begin
        for (int i = 0; i < mw; i++) push(m, 1'b0, rbit(), 1'b0, "mem_wait");
        push(m, 1'b0, rbit(), 1'b1, "mem_rst");
        plan_quiet();
        return;
      end
      nst = (mw > TMO) ? TMO + 1 : mw;
      for (int i = 0; i < nst; i++) push(m, 1'b0, rbit(), 1'b0, "mem_wait");
      if (mw > TMO) begin
        do_trap(2'd3, hold);
        return;
      end
      if (op == O_STORE) begin
        m.pcwe = 1'b1;
        push(m, 1'b1, rbit(), 1'b0, "mem_store_done");
        return;
      end
      push(m, 1'b1, rbit(), 1'b0, "mem_load_done");
    end
    w = blank(ST_WRITEBACK);
    w.rfwe = 1'b1;
    w.pcwe = 1'b1;
    if (op == O_JAL || op == O_JALR) begin
      w.wbs = 2'd2;
      w.pcsel = 1'b1;
    end else if (op == O_LOAD) begin
      w.wbs = 2'd1;
    end
    push(w, rbit(), rbit(), 1'b0, "writeback");
  endtask

  // ---------------- driver / checker ----------------
  task automatic run_all();
    stim_t       s;
    logic [19:0] e;
    logic [19:0] obs;
    string       t;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] m_cyc = '0;
    logic [31:0] m_ret = '0;
    vec_t        ev;
`endif
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      rst       = s.rst;
      mem_ready = s.rdy;
      br_taken  = s.br;
      opcode    = s.op;
      funct3    = 3'($urandom_range(0, 7));
      @(negedge clk);
      obs = {state_dbg, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we,
             wb_sel, op1_sel, op2_sel, alu_en, trap, trap_cause};
      check_eq(t, 32'(obs), 32'(e));
`ifdef CTRL_PERF_CNT_EN
      check_eq({t, "_cycle_cnt"}, cycle_cnt, m_cyc);
      check_eq({t, "_instret_cnt"}, instret_cnt, m_ret);
      ev = vec_t'(e);
      if (s.rst) begin
        m_cyc = '0;
        m_ret = '0;
      end else if (ev.st != 3'(ST_TRAP)) begin
        m_cyc = m_cyc + 32'd1;
        if (ev.pcwe) m_ret = m_ret + 32'd1;
      end
`endif
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    int r, fw, mw;
    logic [6:0] op;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    plan_quiet();
    // Directed cases
    plan_instr(O_OPIMM,  1'b0, 0, 0, 1'b0, 3);   // ADDI, zero wait: 4 cycles
    plan_instr(O_LOAD,   1'b0, 0, 3, 1'b0, 3);   // LW, 3 MEM stalls: 8 cycles
    plan_instr(O_BRANCH, 1'b1, 0, 0, 1'b0, 3);
    plan_instr(O_BRANCH, 1'b0, 0, 0, 1'b0, 3);
    plan_instr(7'h00,    1'b0, 0, 0, 1'b0, 20);  // illegal, trap held 20 cycles
    plan_instr(O_OPIMM,  1'b0, 5, 0, 1'b0, 3);   // fetch never ready: timeout
    plan_instr(O_OPIMM,  1'b0, 4, 0, 1'b0, 3);   // ready exactly at the limit
    plan_instr(O_STORE,  1'b0, 0, 2, 1'b1, 3);   // rst during store wait
    plan_instr(O_STORE,  1'b0, 1, 4, 1'b0, 3);
    plan_instr(O_LOAD,   1'b0, 0, 5, 1'b0, 3);   // MEM timeout
    plan_instr(O_JAL,    1'b0, 0, 0, 1'b0, 3);
    plan_instr(O_JALR,   1'b0, 2, 0, 1'b0, 3);
    plan_instr(O_LUI,    1'b0, 0, 0, 1'b0, 3);
    plan_instr(O_AUIPC,  1'b0, 0, 0, 1'b0, 3);
    plan_instr(O_OP,     1'b0, 0, 0, 1'b0, 3);
    plan_instr(O_FENCE,  1'b0, 0, 0, 1'b0, 3);
    plan_instr(O_SYSTEM, 1'b0, 0, 0, 1'b0, 4);
    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 15);
      if (r < 11)       op = legal_ops[r];
      else if (r < 13)  op = 7'($urandom_range(0, 127));
      else              op = (r == 13) ? O_OP : O_OPIMM;
      fw = ($urandom_range(0, 19) == 0) ? TMO + 1 : $urandom_range(0, TMO);
      mw = ($urandom_range(0, 19) == 0) ? TMO + 1 : $urandom_range(0, TMO);
      if ($urandom_range(0, 24) == 0)
        plan_instr(op, rbit(), fw, (mw > TMO) ? TMO : mw, 1'b1, 2);
      else
        plan_instr(op, rbit(), fw, mw, 1'b0, $urandom_range(1, 5));
    end
    run_all();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
